yin_tau_search: RTL and testbench
=================================

# yin_tau_search

Streaming successor to the YIN minimum-tau stage. It consumes one normalised difference value d'(tau) per accepted beat, in ascending tau order, for a frame of MAX_TAU values. It finds the first tau whose value falls below an average-derived threshold, then follows the descent to that dip's local minimum. If no value crosses the threshold, it falls back to the global minimum and flags the frame unvoiced. It sits between the difference/normalisation stage and the pitch-output logic, and replaces the divider-based threshold with a multiply-shift.

## Interface
- INTERMEDIATE_DATA_WIDTH, 64, width W of d' values, average and threshold
- MAX_TAU, 40, values per frame (tau 0..MAX_TAU-1)
- TAU_BITS, 8, width of tau outputs; must satisfy 2**TAU_BITS >= MAX_TAU
- MIN_TAU, 2, values with tau < MIN_TAU are consumed but never selected
- THRESH_NUM, 1, threshold numerator
- THRESH_SHIFT, 7, threshold = (average*THRESH_NUM) >> THRESH_SHIFT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; latches average and begins a frame
- average  in  W  frame mean of the difference function, sampled with start
- in_valid  in  1  in_value is valid
- in_value  in  W  d'(tau) for the next tau
- in_ready  out  1  block accepts in_value this cycle
- busy  out  1  high from the start-accept edge until DONE
- ready  out  1  result valid; held until the next accepted start
- min_tau  out  TAU_BITS  selected tau
- min_value  out  W  d' at min_tau
- voiced  out  1  1 = threshold crossing found; 0 = global-minimum fallback

## Operation
- States: IDLE, THRESH, SEARCH, DESCEND, DRAIN, DONE.
- Beat = in_valid && in_ready. The tau counter starts at 0 and increments on every beat. in_valid while in_ready=0 is ignored.
- IDLE/DONE + start: latch average, clear ready, set busy, go to THRESH. start in any other state is ignored.
- THRESH (1 cycle, in_ready=0):
  - Compute the full-width product average*THRESH_NUM, then shift right by THRESH_SHIFT.
  - If the result exceeds W bits, saturate to all ones. Register it as the threshold.
  - Clear the global-min tracker; go to SEARCH.
- SEARCH (in_ready=1):
  - For tau >= MIN_TAU: if value < global min, update the global min (strict <, so the earliest tau wins ties).
  - If value < threshold (strict; equality does not qualify), set candidate = (tau, value) and go to DESCEND.
- DESCEND (in_ready=1):
  - If value < candidate value, update the candidate.
  - Otherwise (>=), freeze the candidate and go to DRAIN. Equality stops descent and keeps the earlier tau.
- DRAIN (in_ready=1): consume the remaining values without evaluating them. Every frame consumes exactly MAX_TAU beats so the upstream frame alignment is preserved.
- Frame end (beat with tau == MAX_TAU-1), from any of SEARCH, DESCEND or DRAIN, after that beat's evaluation:
  - Candidate exists: min_tau/min_value = candidate, voiced=1.
  - No candidate: min_tau/min_value = global min, voiced=0.
  - Go to DONE.
- Edge case, MIN_TAU >= MAX_TAU: no tau is ever eligible; the result is min_tau=0, min_value=all ones, voiced=0.
- DONE: ready=1, busy=0, in_ready=0; outputs stable until the next start.
- reset in any state:
  - State goes to IDLE; the partial frame is discarded.
  - Outputs return to reset values: ready=0, busy=0, in_ready=0, voiced=0, min_tau=0, min_value=0.
  - The upstream producer must restart the frame.

## Timing
- All outputs are registered. in_ready is a registered function of state.
- start accepted at edge E: THRESH during E..E+1, in_ready=1 after edge E+1.
- First beat possible at edge E+2. At full rate the last beat lands at edge E+MAX_TAU+1, and ready=1 with valid outputs immediately after it (MAX_TAU+2 cycles from start).
- Stalls (in_valid=0) add exactly one cycle each. The result must not depend on stall pattern.
- start arriving in the same cycle ready rises (DONE entry) is ignored. start is honoured from the first cycle ready=1 is visible.
- reset has priority over start and over beats in the same cycle.

## Test plan
All scenarios use MAX_TAU=8, MIN_TAU=1, THRESH_NUM=1, THRESH_SHIFT=2, average=400 (threshold 100) unless noted.
- Voiced dip: 500,300,200,90,70,80,60,300 at full rate -> min_tau=4, min_value=70, voiced=1. The later 60 is ignored. ready rises exactly 10 cycles after the start edge.
- No crossing: 500,300,200,150,120,110,130,140 -> min_tau=5, min_value=110, voiced=0.
- Boundaries: 10,300,200,100,99,99,200,300 -> tau 0 ignored (below MIN_TAU); 100 does not qualify (equality); descent stops on the equal 99 -> min_tau=4, min_value=99, voiced=1.
- Back-pressure: scenario 1 with in_valid low for 3 cycles between beats 2 and 3, and in_valid high during THRESH -> identical result. ready is 3 cycles later. No extra beat is counted during THRESH.
- Reset mid-frame: reset after 4 beats -> next cycle all outputs at reset values. A new start plus scenario 2 data gives scenario 2's result. start while busy is ignored.
- Saturation: W=16, average=16'hFFFF, THRESH_NUM=3, THRESH_SHIFT=0 -> threshold 16'hFFFF. Data 0,65534,… -> min_tau=1, voiced=1.

Source files
------------

// File: rtl/yin_tau_search.sv
// Streaming YIN minimum-tau search: first dip below an average-derived threshold,
// followed down to its local minimum, with a global-minimum fallback for unvoiced frames.
module yin_tau_search #(
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int MAX_TAU                 = 40,
    parameter int TAU_BITS                = 8,
    parameter int MIN_TAU                 = 2,
    parameter int THRESH_NUM              = 1,
    parameter int THRESH_SHIFT            = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [INTERMEDIATE_DATA_WIDTH-1:0] average,
    input  logic                               in_valid,
    input  logic [INTERMEDIATE_DATA_WIDTH-1:0] in_value,
    output logic                               in_ready,
    output logic                               busy,
    output logic                               ready,
    output logic [TAU_BITS-1:0]                min_tau,
    output logic [INTERMEDIATE_DATA_WIDTH-1:0] min_value,
    output logic                               voiced
);

    localparam int W = INTERMEDIATE_DATA_WIDTH;
    localparam logic [TAU_BITS-1:0] LAST_TAU = TAU_BITS'(MAX_TAU - 1);
    localparam logic [31:0]         MIN_TAU_U = MIN_TAU;

    typedef enum logic [2:0] {IDLE, THRESH, SEARCH, DESCEND, DRAIN, DONE} state_t;

    state_t            state, state_next;
    logic [TAU_BITS-1:0] tau;
    logic              cand_valid;
    logic [W-1:0]      avg_r, thresh;
    logic [W-1:0]      gmin_value, cand_value;
    logic [TAU_BITS-1:0] gmin_tau, cand_tau;

    logic              beat, last, eligible, accept_start;
    logic              hit, gmin_upd, desc_upd, cand_now_valid;
    logic [W-1:0]      cand_value_now, gmin_value_now;
    logic [TAU_BITS-1:0] cand_tau_now, gmin_tau_now;

    // Multiply-shift threshold, clamped to all ones when the shifted product overflows W bits.
    function automatic logic [W-1:0] sat_thresh(input logic [W-1:0] avg);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] shifted;
        prod    = {{W{1'b0}}, avg} * (2*W)'(THRESH_NUM);
        shifted = prod >> THRESH_SHIFT;
        if (|shifted[2*W-1:W])
            return '1;
        return shifted[W-1:0];
    endfunction

    always_comb begin
        beat         = in_valid && in_ready;
        last         = beat && (tau == LAST_TAU);
        eligible     = (32'(tau) >= MIN_TAU_U);
        accept_start = start && (state == IDLE || state == DONE);

        hit      = beat && (state == SEARCH) && eligible && (in_value < thresh);
        gmin_upd = beat && (state == SEARCH) && eligible && (in_value < gmin_value);
        desc_upd = beat && (state == DESCEND) && (in_value < cand_value);

        cand_now_valid = cand_valid || hit;
        cand_tau_now   = (hit || desc_upd) ? tau : cand_tau;
        cand_value_now = (hit || desc_upd) ? in_value : cand_value;
        gmin_tau_now   = gmin_upd ? tau : gmin_tau;
        gmin_value_now = gmin_upd ? in_value : gmin_value;

        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = THRESH;
            THRESH:     state_next = SEARCH;
            SEARCH: begin
                if (last)     state_next = DONE;
                else if (hit) state_next = DESCEND;
            end
            DESCEND: begin
                if (last)                  state_next = DONE;
                else if (beat && !desc_upd) state_next = DRAIN;
            end
            DRAIN:      if (last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Control and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            voiced     <= 1'b0;
            min_tau    <= '0;
            min_value  <= '0;
            cand_valid <= 1'b0;
            tau        <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == SEARCH) || (state_next == DESCEND) || (state_next == DRAIN);
            busy     <= (state_next != IDLE) && (state_next != DONE);
            ready    <= (state_next == DONE);
            if (accept_start) begin
                tau        <= '0;
                cand_valid <= 1'b0;
            end
            if (beat) begin
                tau        <= tau + 1'b1;
                cand_valid <= cand_now_valid;
            end
            if (last) begin
                voiced    <= cand_now_valid;
                min_tau   <= cand_now_valid ? cand_tau_now : gmin_tau_now;
                min_value <= cand_now_valid ? cand_value_now : gmin_value_now;
            end
        end
    end

    // Datapath registers carry no reset; they are always rewritten before use in a frame.
    always_ff @(posedge clk) begin
        if (accept_start)
            avg_r <= average;
        if (state == THRESH) begin
            thresh     <= sat_thresh(avg_r);
            gmin_value <= '1;
            gmin_tau   <= '0;
        end
        if (gmin_upd) begin
            gmin_value <= in_value;
            gmin_tau   <= tau;
        end
        if (hit || desc_upd) begin
            cand_value <= in_value;
            cand_tau   <= tau;
        end
    end

endmodule

// File: tb/tb_yin_tau_search.sv
// Directed bench for yin_tau_search: voiced/unvoiced frames, boundaries,
// back-pressure, mid-frame reset, ignored start and threshold saturation.
module tb_yin_tau_search;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid;
    logic [63:0] average, in_value;
    logic        in_ready, busy, ready, voiced;
    logic [7:0]  min_tau;
    logic [63:0] min_value;

    logic        s_start, s_in_valid;
    logic [15:0] s_average, s_in_value;
    logic        s_in_ready, s_busy, s_ready, s_voiced;
    logic [7:0]  s_min_tau;
    logic [15:0] s_min_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    yin_tau_search #(
        .INTERMEDIATE_DATA_WIDTH(64), .MAX_TAU(8), .TAU_BITS(8),
        .MIN_TAU(1), .THRESH_NUM(1), .THRESH_SHIFT(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .average(average),
        .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
        .busy(busy), .ready(ready), .min_tau(min_tau),
        .min_value(min_value), .voiced(voiced)
    );

    yin_tau_search #(
        .INTERMEDIATE_DATA_WIDTH(16), .MAX_TAU(8), .TAU_BITS(8),
        .MIN_TAU(1), .THRESH_NUM(3), .THRESH_SHIFT(0)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .average(s_average),
        .in_valid(s_in_valid), .in_value(s_in_value), .in_ready(s_in_ready),
        .busy(s_busy), .ready(s_ready), .min_tau(s_min_tau),
        .min_value(s_min_value), .voiced(s_voiced)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one frame on the main instance. Latency is counted from the cycle start is driven.
    task automatic run_frame(input logic [63:0] vals [8], input int stall_n,
                             input int busy_start_at, output int latency);
        int t0;
        int n;
        bit rdy;
        @(negedge clk);
        start = 1'b1;
        average = 64'd400;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("thresh_in_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3 && stall_n > 0) begin
                in_valid = 1'b0;
                repeat (stall_n) @(negedge clk);
            end
            in_valid = 1'b1;
            in_value = vals[i];
            if (i == busy_start_at) begin
                start = 1'b1;
                average = 64'd4000;
            end
            n = 0;
            do begin
                rdy = in_ready;
                @(negedge clk);
                start = 1'b0;
                n++;
            end while (!rdy && n < 20);
            check("beat_accept", {63'd0, rdy}, 64'd1);
        end
        in_valid = 1'b0;
        n = 0;
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        latency = cyc - t0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] etau,
                                input logic [63:0] eval, input logic evoiced);
        check({tag, "_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_min_tau"}, {56'd0, min_tau}, {56'd0, etau});
        check({tag, "_min_value"}, min_value, eval);
        check({tag, "_voiced"}, {63'd0, voiced}, {63'd0, evoiced});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_voiced"}, {63'd0, voiced}, 64'd0);
        check({tag, "_min_tau"}, {56'd0, min_tau}, 64'd0);
        check({tag, "_min_value"}, min_value, 64'd0);
    endtask

    initial begin
        logic [63:0] v [8];
        logic [15:0] sv [8];
        int lat;
        int n;
        bit rdy;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; average = '0; in_value = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_average = '0; s_in_value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("por");

        // Voiced dip at full rate; the later 60 must not be picked.
        v = '{64'd500, 64'd300, 64'd200, 64'd90, 64'd70, 64'd80, 64'd60, 64'd300};
        run_frame(v, 0, -1, lat);
        check_result("dip", 8'd4, 64'd70, 1'b1);
        check("dip_latency", 64'(lat), 64'd10);

        // No crossing: global-minimum fallback.
        v = '{64'd500, 64'd300, 64'd200, 64'd150, 64'd120, 64'd110, 64'd130, 64'd140};
        run_frame(v, 0, -1, lat);
        check_result("nocross", 8'd5, 64'd110, 1'b0);

        // tau 0 ineligible, equality at threshold fails, equal value stops descent.
        v = '{64'd10, 64'd300, 64'd200, 64'd100, 64'd99, 64'd99, 64'd200, 64'd300};
        run_frame(v, 0, -1, lat);
        check_result("bound", 8'd4, 64'd99, 1'b1);

        // Back-pressure: three idle cycles before beat 3, valid already high in THRESH.
        v = '{64'd500, 64'd300, 64'd200, 64'd90, 64'd70, 64'd80, 64'd60, 64'd300};
        run_frame(v, 3, -1, lat);
        check_result("stall", 8'd4, 64'd70, 1'b1);
        check("stall_latency", 64'(lat), 64'd13);

        // Reset after four beats, asserted together with a beat.
        @(negedge clk);
        start = 1'b1; average = 64'd400;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_value = 64'd50;
            n = 0;
            do begin
                rdy = in_ready;
                @(negedge clk);
                n++;
            end while (!rdy && n < 20);
            check("rst_beat_accept", {63'd0, rdy}, 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        check_reset_state("midrst");

        // Fresh frame after reset; a start pulse mid-frame (threshold 1000) must be ignored.
        v = '{64'd500, 64'd300, 64'd200, 64'd150, 64'd120, 64'd110, 64'd130, 64'd140};
        run_frame(v, 0, 2, lat);
        check_result("postrst", 8'd5, 64'd110, 1'b0);
        check("postrst_latency", 64'(lat), 64'd10);

        // Saturating threshold on the 16-bit instance: 3*0xFFFF clamps to 0xFFFF.
        sv = '{16'd0, 16'd65534, 16'd65535, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        @(negedge clk);
        s_start = 1'b1; s_average = 16'hFFFF;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_in_valid = 1'b1;
            s_in_value = sv[i];
            n = 0;
            do begin
                rdy = s_in_ready;
                @(negedge clk);
                n++;
            end while (!rdy && n < 20);
            check("sat_beat_accept", {63'd0, rdy}, 64'd1);
        end
        s_in_valid = 1'b0;
        n = 0;
        while (!s_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("sat_ready", {63'd0, s_ready}, 64'd1);
        check("sat_min_tau", {56'd0, s_min_tau}, 64'd1);
        check("sat_min_value", {48'd0, s_min_value}, 64'd65534);
        check("sat_voiced", {63'd0, s_voiced}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
